crc16_rx_checker: RTL and testbench

Receive-side companion to the byte-parallel CRC generator. It consumes a frame of payload bytes followed by the two appended CRC bytes, MSB first, one byte per cycle. It recomputes CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF, no reflection, no final XOR) and reports pass/fail by zero-residue check. It sits at the end of the byte link, after the deframer, and feeds frame-accept logic.

---
 rtl/crc16_pkg.sv | 36 +++
 rtl/crc16_byte_step.sv | 18 +
 rtl/crc16_rx_checker.sv | 132 +++++++++++++
 tb/tb_crc16_rx_checker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/crc16_pkg.sv
// Shared CRC-16/CCITT-FALSE definitions for the byte-parallel generator and
// the receive-side checker: polynomial/seed constants, FSM encodings and the
// byte-wide update function.
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // Checker FSM encodings, kept as plain constants so older tools that
  // reuse this package see the same numeric values.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Eight MSB-first shift/XOR steps collapsed into one combinational update,
  // with the polynomial as an argument so parameterised users can override it.
  function automatic logic [15:0] crc16_byte_next_poly(input logic [15:0] crc,
                                                       input logic [7:0]  data,
                                                       input logic [15:0] poly);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ poly;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Default-polynomial form used by the generator.
  function automatic logic [15:0] crc16_byte_next(input logic [15:0] crc,
                                                  input logic [7:0]  data);
    return crc16_byte_next_poly(crc, data, CRC16_POLY);
  endfunction

endpackage

// File: rtl/crc16_byte_step.sv
// Combinational one-byte CRC update: folds data into crc_prev in a single
// cycle using the parameterised polynomial.
module crc16_byte_step
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_POLY
) (
  input  logic [15:0] crc_prev,
  input  logic [7:0]  data,
  output logic [15:0] crc_next
);

  // Pure function of the inputs; the caller owns the register.
  always_comb begin
    crc_next = crc16_byte_next_poly(crc_prev, data, POLY);
  end

endmodule

// File: rtl/crc16_rx_checker.sv
// Receive-side CRC-16 checker. Folds payload plus the two trailing CRC bytes
// into a running register and declares the frame good when the residue is
// zero and the length is legal. Verdicts are computed from the next-state
// values so they appear together with the done pulse.
module crc16_rx_checker
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY      = CRC16_POLY,
  parameter logic [15:0] INIT      = CRC16_INIT,
  parameter int          MAX_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        d_finish,
  input  logic [7:0]  crc_in,
  output logic [15:0] crc_out,
  output logic [15:0] byte_count,
  output logic        busy,
  output logic        done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        len_err
);

  // Count value at which the frame is known to be too long; bytes beyond it
  // no longer touch the CRC or the counter.
  localparam logic [15:0] COUNT_SAT = 16'(MAX_BYTES + 1);

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [15:0] crc_next;
  logic [15:0] count_next;
  logic        overflow;
  logic        overflow_next;
  logic        verdict_clear;
  logic [15:0] step_seed;
  logic [15:0] step_out;
  logic        len_bad;
  logic        residue_ok;

  // A new frame starts from INIT, so the first byte uses INIT as prior state.
  always_comb begin
    step_seed = ((state == IDLE) || (state == DONE)) ? INIT : crc_out;
  end

  crc16_byte_step #(
    .POLY(POLY)
  ) u_step (
    .crc_prev(step_seed),
    .data    (crc_in),
    .crc_next(step_out)
  );

  // Next-state, CRC, counter and overflow decisions for the frame FSM.
  always_comb begin
    state_next    = state;
    crc_next      = crc_out;
    count_next    = byte_count;
    overflow_next = overflow;
    verdict_clear = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (load) begin
          crc_next      = step_out;
          count_next    = 16'd1;
          overflow_next = 1'b0;
          verdict_clear = 1'b1;
          state_next    = d_finish ? CHECK : RECV;
        end else if (d_finish) begin
          // Empty frame: judged immediately, always a length error.
          crc_next      = INIT;
          count_next    = 16'd0;
          overflow_next = 1'b0;
          verdict_clear = 1'b1;
          state_next    = CHECK;
        end
      end
      RECV: begin
        if (load && (byte_count != COUNT_SAT)) begin
          crc_next   = step_out;
          count_next = byte_count + 16'd1;
          if ((byte_count + 16'd1) == COUNT_SAT) overflow_next = 1'b1;
        end
        if (d_finish) state_next = CHECK;
      end
      CHECK: begin
        // Bytes and d_finish arriving here are dropped on purpose.
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Verdict from the values that will be registered on this edge.
  always_comb begin
    len_bad    = (count_next < 16'd2) | overflow_next;
    residue_ok = ~len_bad & (crc_next == 16'h0000);
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      crc_out    <= INIT;
      byte_count <= 16'd0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      crc_ok     <= 1'b0;
      crc_err    <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      state      <= state_next;
      crc_out    <= crc_next;
      byte_count <= count_next;
      overflow   <= overflow_next;
      busy       <= (state_next == RECV);
      done       <= (state_next == CHECK);
      if (state_next == CHECK) begin
        len_err <= len_bad;
        crc_ok  <= residue_ok;
        crc_err <= ~residue_ok;
      end else if (verdict_clear) begin
        len_err <= 1'b0;
        crc_ok  <= 1'b0;
        crc_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_crc16_rx_checker.sv
// Self-checking bench for crc16_rx_checker: directed frames from the test
// plan followed by randomized frames, all checked against a bit-serial
// long-division model of CRC-16/CCITT-FALSE.
module tb_crc16_rx_checker;

  localparam int MAX_B = 16;

  typedef logic [7:0] u8_t;
  typedef u8_t        u8_q_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        d_finish = 1'b0;
  logic [7:0]  crc_in = 8'h00;
  logic [15:0] crc_out;
  logic [15:0] byte_count;
  logic        busy;
  logic        done;
  logic        crc_ok;
  logic        crc_err;
  logic        len_err;

  int checks = 0;
  int errors = 0;

  crc16_rx_checker #(.MAX_BYTES(MAX_B)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .d_finish  (d_finish),
    .crc_in    (crc_in),
    .crc_out   (crc_out),
    .byte_count(byte_count),
    .busy      (busy),
    .done      (done),
    .crc_ok    (crc_ok),
    .crc_err   (crc_err),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  // Bit-serial polynomial division over the first n bytes, MSB first.
  function automatic logic [15:0] model_crc(input u8_q_t q, input int n);
    logic [15:0] r;
    logic        fb;
    r = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = r[15] ^ q[i][b];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h1021;
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame (optional idle gap, optional illegal load in CHECK)
  // and checks every cycle plus the verdict.
  task automatic send_frame(input u8_q_t q, input int gap_after, input int gap_len,
                            input bit poke_check, input string name);
    int          n;
    int          kept;
    logic        exp_len;
    logic        exp_ok;
    logic [15:0] exp_crc;
    n = q.size();
    kept = 0;
    if (n == 0) begin
      d_finish = 1'b1;
      @(posedge clk); #1;
      d_finish = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      load = 1'b1; crc_in = q[i]; d_finish = (i == n - 1);
      @(posedge clk); #1;
      load = 1'b0; d_finish = 1'b0;
      kept = (i + 1 > MAX_B + 1) ? MAX_B + 1 : i + 1;
      check({name, " crc_out"}, 32'(crc_out), 32'(model_crc(q, kept)));
      check({name, " byte_count"}, 32'(byte_count), 32'(kept));
      if (i != n - 1) begin
        check({name, " busy"}, 32'(busy), 32'd1);
        if (i == 0) check({name, " verdict_cleared"}, 32'({done, crc_ok, crc_err, len_err}), 32'd0);
      end
      if ((i == gap_after) && (i != n - 1)) begin
        repeat (gap_len) begin
          @(posedge clk); #1;
          check({name, " gap_hold"}, 32'(crc_out), 32'(model_crc(q, kept)));
          check({name, " gap_busy"}, 32'(busy), 32'd1);
        end
      end
    end
    exp_len = (n < 2) || (n > MAX_B);
    exp_ok  = !exp_len && (model_crc(q, n) == 16'h0000);
    exp_crc = model_crc(q, kept);
    // First cycle after the edge that sampled d_finish: done and verdict.
    check({name, " done"}, 32'(done), 32'd1);
    check({name, " busy_chk"}, 32'(busy), 32'd0);
    check({name, " len_err"}, 32'(len_err), 32'(exp_len));
    check({name, " crc_ok"}, 32'(crc_ok), 32'(exp_ok));
    check({name, " crc_err"}, 32'(crc_err), 32'(!exp_ok));
    check({name, " final_count"}, 32'(byte_count), 32'(kept));
    if (poke_check) begin
      load = 1'b1; crc_in = 8'($urandom); d_finish = 1'b1;
    end
    @(posedge clk); #1;
    load = 1'b0; d_finish = 1'b0;
    check({name, " done_pulse"}, 32'(done), 32'd0);
    check({name, " held_verdict"}, 32'({crc_ok, crc_err, len_err}), 32'({exp_ok, !exp_ok, exp_len}));
    check({name, " held_count"}, 32'(byte_count), 32'(kept));
    if (n > 0) check({name, " held_crc"}, 32'(crc_out), 32'(exp_crc));
    check({name, " idle_busy"}, 32'(busy), 32'd0);
    $display("frame %s len=%0d ok=%0b len_err=%0b crc=%04h", name, n, crc_ok, len_err, crc_out);
  endtask

  initial begin
    u8_q_t q;
    u8_q_t std9;
    logic [15:0] c;
    int len;

    std9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    // Reset state.
    #2 rst = 1'b0;
    #2;
    check("rst crc_out", 32'(crc_out), 32'hFFFF);
    check("rst byte_count", 32'(byte_count), 32'd0);
    check("rst flags", 32'({busy, done, crc_ok, crc_err, len_err}), 32'd0);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;

    // Standard check string with its correct CRC.
    q = std9; q.push_back(8'h29); q.push_back(8'hB1);
    send_frame(q, -1, 0, 1'b0, "std_good");
    check("std_good residue", 32'(crc_out), 32'h0000);
    check("std_good count11", 32'(byte_count), 32'd11);
    check("std_good ok", 32'(crc_ok), 32'd1);

    // Corrupted last CRC byte.
    q = std9; q.push_back(8'h29); q.push_back(8'hB0);
    send_frame(q, -1, 0, 1'b0, "std_bad");
    check("std_bad err", 32'({crc_ok, crc_err, len_err}), 32'b010);

    // Empty payload plus its CRC.
    q = '{8'hFF, 8'hFF};
    send_frame(q, -1, 0, 1'b0, "ffff");
    check("ffff ok", 32'(crc_ok), 32'd1);

    // Single byte.
    q = '{8'h00};
    send_frame(q, -1, 0, 1'b0, "one_byte");
    check("one_byte crc", 32'(crc_out), 32'hE1F0);
    check("one_byte err", 32'({crc_err, len_err}), 32'b11);

    // d_finish alone.
    q = {};
    send_frame(q, -1, 0, 1'b0, "empty");

    // Gap between bytes 4 and 5, plus a dropped load during CHECK.
    q = std9; q.push_back(8'h29); q.push_back(8'hB1);
    send_frame(q, 3, 3, 1'b1, "gap_good");
    check("gap_good ok", 32'(crc_ok), 32'd1);

    // Randomized back-to-back frames, including over-length ones.
    for (int f = 0; f < 40; f++) begin
      q = {};
      len = int'($urandom_range(0, MAX_B + 4));
      if ((len >= 2) && ($urandom_range(0, 1) == 1)) begin
        for (int i = 0; i < len - 2; i++) q.push_back(8'($urandom));
        c = model_crc(q, len - 2);
        q.push_back(c[15:8]); q.push_back(c[7:0]);
      end else begin
        for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      end
      send_frame(q, int'($urandom_range(0, 20)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $sformatf("rand%0d", f));
    end

    // Asynchronous reset after byte 5 aborts the frame.
    for (int i = 0; i < 5; i++) begin
      load = 1'b1; crc_in = std9[i];
      @(posedge clk); #1;
    end
    load = 1'b0;
    rst = 1'b0;
    #1;
    check("abort crc_out", 32'(crc_out), 32'hFFFF);
    check("abort byte_count", 32'(byte_count), 32'd0);
    check("abort busy_done", 32'({busy, done}), 32'd0);
    @(posedge clk); #2 rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort no_done", 32'(done), 32'd0);
    end
    q = std9; q.push_back(8'h29); q.push_back(8'hB1);
    send_frame(q, -1, 0, 1'b0, "after_abort");
    check("after_abort ok", 32'(crc_ok), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
